// File: rtl/shifter_pkg.sv
// Shared constants and types for the sequential shifter family.
// Holds the operand geometry, the sequencer state encoding and its output flags.
package shifter_pkg;

    localparam int WIDTH = 64;
    localparam int SHW   = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } shr_state_t;

    typedef struct packed {
        logic ready;
        logic busy;
        logic done;
    } shr_flags_t;

    // Handshake flags are a pure function of the state they accompany.
    function automatic shr_flags_t flagsFor(shr_state_t s);
        shr_flags_t f;
        f = '{ready: 1'b1, busy: 1'b0, done: 1'b0};
        case (s)
            SHIFT:   f = '{ready: 1'b0, busy: 1'b1, done: 1'b0};
            DONE:    f = '{ready: 1'b1, busy: 1'b0, done: 1'b1};
            default: f = '{ready: 1'b1, busy: 1'b0, done: 1'b0};
        endcase
        return f;
    endfunction

endpackage

// File: rtl/right_shifter_seq_if.sv
// Request/completion bundle between a requester and the sequential right shifter.
interface right_shifter_seq_if #(
    parameter int WIDTH = shifter_pkg::WIDTH,
    parameter int SHW   = shifter_pkg::SHW
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   shamt;
    logic             arith;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, a, shamt, arith,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, a, shamt, arith,
        output ready, busy, done, result
    );
endinterface

// File: rtl/right_shifter_1.sv
// Combinational single-position right shift with an explicit fill bit;
// the right-direction mirror of left_shifter_1.
module right_shifter_1 #(
    parameter int WIDTH = shifter_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic             fill,
    output logic [WIDTH-1:0] y
);
    // Same as {fill, a[WIDTH-1:1]}; the shifted-out LSB is simply dropped.
    assign y = {fill, {(WIDTH-1){1'b0}}} | (a >> 1);
endmodule

// File: rtl/right_shifter_seq.sv
// Multi-cycle right shifter: one bit per clock through right_shifter_1,
// sequenced by a start/done handshake with registered status flags.
import shifter_pkg::*;

module right_shifter_seq #(
    parameter int WIDTH = shifter_pkg::WIDTH,
    parameter int SHW   = shifter_pkg::SHW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    right_shifter_seq_if.slave   bus
);
    shr_state_t       state;
    shr_flags_t       flags;
    logic [WIDTH-1:0] shiftReg;
    logic [WIDTH-1:0] shiftedVal;
    logic [SHW-1:0]   count;
    logic             fillBit;

    right_shifter_1 #(.WIDTH(WIDTH)) u_stage (
        .a    (shiftReg),
        .fill (fillBit),
        .y    (shiftedVal)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            flags    <= flagsFor(IDLE);
            shiftReg <= '0;
            count    <= '0;
            fillBit  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        shiftReg <= bus.a;
                        count    <= bus.shamt;
                        // NOTE: fill is frozen at accept; the operand port may change mid-shift.
                        fillBit  <= bus.arith & bus.a[WIDTH-1];
                        if (bus.shamt != '0) begin
                            state <= SHIFT;
                            flags <= flagsFor(SHIFT);
                        end else begin
                            state <= DONE;
                            flags <= flagsFor(DONE);
                        end
                    end else begin
                        state <= IDLE;
                        flags <= flagsFor(IDLE);
                    end
                end
                SHIFT: begin
                    shiftReg <= shiftedVal;
                    count    <= count - SHW'(1);
                    if (count == SHW'(1)) begin
                        state <= DONE;
                        flags <= flagsFor(DONE);
                    end
                end
                default: begin
                    state <= IDLE;
                    flags <= flagsFor(IDLE);
                end
            endcase
        end
    end

    assign bus.ready  = flags.ready;
    assign bus.busy   = flags.busy;
    assign bus.done   = flags.done;
    assign bus.result = shiftReg;

endmodule

// File: tb/tb_right_shifter_seq.sv
// Self-checking bench for right_shifter_seq: directed vectors, hand-built
// handshake corner cases and a randomized sweep against a reference model.
module tb_right_shifter_seq;
    localparam int WIDTH   = 64;
    localparam int SHW     = 6;
    localparam int MAX_LAT = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nChecks = 0;
    int   nFails  = 0;

    right_shifter_seq_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    right_shifter_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        int               shamt;
        logic             arith;
        logic [WIDTH-1:0] expected;
    } vec_t;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] refShift(input logic [WIDTH-1:0] a,
                                                  input int sh, input logic arith);
        if (arith) return WIDTH'($signed(a) >>> sh);
        return a >> sh;
    endfunction

    // Called just after a falling edge; returns at the falling edge where done=1.
    task automatic runOp(input string name, input logic [WIDTH-1:0] a,
                         input int sh, input logic arith,
                         input logic [WIDTH-1:0] expected);
        int lat;
        int busyCnt;
        check({name, " ready"}, WIDTH'(bus.ready), WIDTH'(1));
        bus.start = 1'b1;
        bus.a     = a;
        bus.shamt = SHW'(sh);
        bus.arith = arith;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.arith = ~arith;
        lat = 0;
        busyCnt = 0;
        while (!bus.done && lat <= MAX_LAT) begin
            if (bus.busy) busyCnt++;
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, WIDTH'(lat), WIDTH'(sh));
        check({name, " busy cycles"}, WIDTH'(busyCnt), WIDTH'(sh));
        check({name, " result"}, bus.result, expected);
    endtask

    initial begin
        vec_t vecs[$];
        logic [WIDTH-1:0] ra;
        int   rsh;
        logic rar;
        int   lat;
        logic sawDone;

        vecs.push_back('{"logical4", 64'hF000_0000_0000_0001, 4, 1'b0, 64'h0F00_0000_0000_0000});
        vecs.push_back('{"arith63", 64'h8000_0000_0000_0000, 63, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{"logical63", 64'h8000_0000_0000_0000, 63, 1'b0, 64'h0000_0000_0000_0001});
        vecs.push_back('{"zero", 64'h1234_5678_9ABC_DEF0, 0, 1'b1, 64'h1234_5678_9ABC_DEF0});
        vecs.push_back('{"arith1pos", 64'h7000_0000_0000_0002, 1, 1'b1, 64'h3800_0000_0000_0001});
        vecs.push_back('{"arith8neg", 64'hC000_0000_0000_FF00, 8, 1'b1, 64'hFFC0_0000_0000_00FF});

        bus.start = 1'b0;
        bus.a     = '0;
        bus.shamt = '0;
        bus.arith = 1'b0;

        #12;
        check("reset ready",  WIDTH'(bus.ready), WIDTH'(1));
        check("reset busy",   WIDTH'(bus.busy), WIDTH'(0));
        check("reset done",   WIDTH'(bus.done), WIDTH'(0));
        check("reset result", bus.result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            runOp(vecs[i].name, vecs[i].a, vecs[i].shamt, vecs[i].arith, vecs[i].expected);
            @(negedge clk);
            check({vecs[i].name, " done pulse width"}, WIDTH'(bus.done), WIDTH'(0));
            check({vecs[i].name, " result held"}, bus.result, vecs[i].expected);
        end

        // Start pulsed mid-shift must be ignored; start during DONE is accepted.
        bus.start = 1'b1;
        bus.a     = 64'hF000_0000_0000_0001;
        bus.shamt = SHW'(4);
        bus.arith = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat <= MAX_LAT) begin
            if (lat == 1) begin
                bus.start = 1'b1;
                bus.a     = 64'hDEAD_BEEF_0000_0000;
                bus.shamt = SHW'(1);
                bus.arith = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check("ignored start latency", WIDTH'(lat), WIDTH'(4));
        check("ignored start result", bus.result, 64'h0F00_0000_0000_0000);
        runOp("back-to-back", 64'hFF, 2, 1'b0, 64'h3F);
        @(negedge clk);

        // Asynchronous reset in the middle of a 10-step shift.
        bus.start = 1'b1;
        bus.a     = 64'h8123_4567_89AB_CDEF;
        bus.shamt = SHW'(10);
        bus.arith = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort result", bus.result, '0);
        check("abort busy",   WIDTH'(bus.busy), WIDTH'(0));
        check("abort ready",  WIDTH'(bus.ready), WIDTH'(1));
        sawDone = bus.done;
        repeat (3) begin
            @(negedge clk);
            sawDone |= bus.done;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            sawDone |= bus.done | bus.busy;
        end
        check("abort no done", WIDTH'(sawDone), WIDTH'(0));
        runOp("after abort", 64'h8000_0000_0000_00F0, 5, 1'b1, 64'hFC00_0000_0000_0007);

        for (int n = 0; n < 1000; n++) begin
            ra  = {$urandom(), $urandom()};
            rsh = int'($urandom_range(0, WIDTH - 1));
            rar = 1'($urandom());
            runOp("random", ra, rsh, rar, refShift(ra, rsh, rar));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
